// File: rtl/div_sched.sv
// Execute-stage scheduler for a shared signed/unsigned multi-cycle divider pair.
// Feeds operands to the selected IP, holds its result, and drains flushed operations.
module div_sched #(
  parameter int DATA_WD = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  input  logic [1:0]             req_op,
  input  logic [DATA_WD-1:0]     req_src1,
  input  logic [DATA_WD-1:0]     req_src2,
  input  logic                   flush,
  input  logic                   res_accept,
  output logic                   ready_go,
  output logic [DATA_WD-1:0]     res_hi,
  output logic [DATA_WD-1:0]     res_lo,
  output logic                   busy,
  output logic                   s_dividend_tvalid,
  output logic                   s_divisor_tvalid,
  output logic [DATA_WD-1:0]     s_dividend_tdata,
  output logic [DATA_WD-1:0]     s_divisor_tdata,
  input  logic                   s_dividend_tready,
  input  logic                   s_divisor_tready,
  input  logic                   s_dout_tvalid,
  input  logic [2*DATA_WD-1:0]   s_dout_tdata,
  output logic                   u_dividend_tvalid,
  output logic                   u_divisor_tvalid,
  output logic [DATA_WD-1:0]     u_dividend_tdata,
  output logic [DATA_WD-1:0]     u_divisor_tdata,
  input  logic                   u_dividend_tready,
  input  logic                   u_divisor_tready,
  input  logic                   u_dout_tvalid,
  input  logic [2*DATA_WD-1:0]   u_dout_tdata
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [DATA_WD-1:0]   r_src1;
  logic [DATA_WD-1:0]   r_src2;
  logic [DATA_WD-1:0]   r_resHi;
  logic [DATA_WD-1:0]   r_resLo;
  logic                 r_sel;
  logic                 r_ddSent;
  logic                 r_dvSent;
  logic                 r_cancel;
  logic                 w_ddValid;
  logic                 w_dvValid;
  logic                 w_ddDone;
  logic                 w_dvDone;
  logic                 w_doutValid;
  logic [2*DATA_WD-1:0] w_doutData;
  logic                 w_reqOk;
  logic                 w_latchReq;
  logic                 w_latchRes;
  logic                 w_ddSentNext;
  logic                 w_dvSentNext;
  logic                 w_cancelNext;

  // r_sel steers both the operand channels and the result source (1 = unsigned IP).
  always_comb begin
    w_ddValid   = (r_state == SEND) && !r_ddSent;
    w_dvValid   = (r_state == SEND) && !r_dvSent;
    w_ddDone    = r_ddSent | (w_ddValid & (r_sel ? u_dividend_tready : s_dividend_tready));
    w_dvDone    = r_dvSent | (w_dvValid & (r_sel ? u_divisor_tready : s_divisor_tready));
    w_doutValid = r_sel ? u_dout_tvalid : s_dout_tvalid;
    w_doutData  = r_sel ? u_dout_tdata : s_dout_tdata;
    w_reqOk     = req_valid && (req_op == 2'b01 || req_op == 2'b10);
  end

  assign s_dividend_tvalid = w_ddValid && !r_sel;
  assign s_divisor_tvalid  = w_dvValid && !r_sel;
  assign u_dividend_tvalid = w_ddValid && r_sel;
  assign u_divisor_tvalid  = w_dvValid && r_sel;
  assign s_dividend_tdata  = r_src1;
  assign s_divisor_tdata   = r_src2;
  assign u_dividend_tdata  = r_src1;
  assign u_divisor_tdata   = r_src2;
  assign ready_go          = (r_state == DONE) && !r_cancel;
  assign busy              = (r_state != IDLE);
  assign res_hi            = r_resHi;
  assign res_lo            = r_resLo;

  // Once one operand has reached an IP, its partner must follow even if flushed.
  always_comb begin
    w_stateNext  = r_state;
    w_ddSentNext = w_ddDone;
    w_dvSentNext = w_dvDone;
    w_cancelNext = r_cancel;
    w_latchReq   = 1'b0;
    w_latchRes   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_reqOk && !flush) begin
          w_stateNext  = SEND;
          w_latchReq   = 1'b1;
          w_ddSentNext = 1'b0;
          w_dvSentNext = 1'b0;
          w_cancelNext = 1'b0;
        end
      end
      SEND: begin
        if (flush && !w_ddDone && !w_dvDone) begin
          w_stateNext  = IDLE;
          w_cancelNext = 1'b0;
        end else if (w_ddDone && w_dvDone) begin
          w_stateNext  = (r_cancel || flush) ? DRAIN : WAIT;
          w_cancelNext = r_cancel || flush;
        end else if (flush) begin
          w_cancelNext = 1'b1;
        end
      end
      WAIT: begin
        if (w_doutValid) begin
          w_stateNext = flush ? IDLE : DONE;
          w_latchRes  = !flush;
        end else if (flush) begin
          w_stateNext  = DRAIN;
          w_cancelNext = 1'b1;
        end
      end
      DONE: begin
        if (flush || res_accept) begin
          w_stateNext = IDLE;
        end
      end
      DRAIN: begin
        if (w_doutValid) begin
          w_stateNext  = IDLE;
          w_cancelNext = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_ddSent <= 1'b0;
      r_dvSent <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_ddSent <= w_ddSentNext;
      r_dvSent <= w_dvSentNext;
      r_cancel <= w_cancelNext;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_src1  <= '0;
      r_src2  <= '0;
      r_sel   <= 1'b0;
      r_resHi <= '0;
      r_resLo <= '0;
    end else begin
      if (w_latchReq) begin
        r_src1 <= req_src1;
        r_src2 <= req_src2;
        r_sel  <= req_op[1];
      end
      if (w_latchRes) begin
        r_resLo <= w_doutData[2*DATA_WD-1:DATA_WD];
        r_resHi <= w_doutData[DATA_WD-1:0];
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: two behavioural divider IPs, a transaction-level result model
// and directed scenarios with literal expectations.
module tb_div_sched;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         reqValid;
  logic [1:0]   reqOp;
  logic [W-1:0] src1, src2;
  logic         flush, resAccept;
  logic         readyGo, busy;
  logic [W-1:0] resHi, resLo;
  logic         sDdV, sDvV, sDdR, sDvR, sOutV;
  logic [W-1:0] sDdD, sDvD;
  logic [2*W-1:0] sOutD;
  logic         uDdV, uDvV, uDdR, uDvR, uOutV;
  logic [W-1:0] uDdD, uDvD;
  logic [2*W-1:0] uOutD;

  int total = 0;
  int bad = 0;
  int ipLat = 5;

  always #5 clk = ~clk;

  div_sched #(.DATA_WD(W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(reqValid), .req_op(reqOp),
    .req_src1(src1), .req_src2(src2), .flush(flush), .res_accept(resAccept),
    .ready_go(readyGo), .res_hi(resHi), .res_lo(resLo), .busy(busy),
    .s_dividend_tvalid(sDdV), .s_divisor_tvalid(sDvV),
    .s_dividend_tdata(sDdD), .s_divisor_tdata(sDvD),
    .s_dividend_tready(sDdR), .s_divisor_tready(sDvR),
    .s_dout_tvalid(sOutV), .s_dout_tdata(sOutD),
    .u_dividend_tvalid(uDdV), .u_divisor_tvalid(uDvV),
    .u_dividend_tdata(uDdD), .u_divisor_tdata(uDvD),
    .u_dividend_tready(uDdR), .u_divisor_tready(uDvR),
    .u_dout_tvalid(uOutV), .u_dout_tdata(uOutD)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference division: {quotient, remainder}, truncating toward zero when signed.
  function automatic logic [63:0] divRef(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) return {32'hFFFF_FFFF, a};
    if (uns) return {a / b, a % b};
    return {sa / sb, sa % sb};
  endfunction

  // Divider IP models: operands are queued on handshake; a pair yields one result.
  logic [W-1:0] sDdQ[$], sDvQ[$], uDdQ[$], uDvQ[$];
  int sDdCnt = 0, sDvCnt = 0, sOutCnt = 0, uDdCnt = 0, uDvCnt = 0;
  int sLeft = 0, uLeft = 0;
  logic [63:0] sRes, uRes;

  always @(negedge clk) begin
    if (resetn) begin
      if (sDdV && sDdR) begin sDdQ.push_back(sDdD); sDdCnt++; end
      if (sDvV && sDvR) begin sDvQ.push_back(sDvD); sDvCnt++; end
      if (uDdV && uDdR) begin uDdQ.push_back(uDdD); uDdCnt++; end
      if (uDvV && uDvR) begin uDvQ.push_back(uDvD); uDvCnt++; end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sDdQ.delete(); sDvQ.delete(); uDdQ.delete(); uDvQ.delete();
      sOutV = 1'b0; uOutV = 1'b0; sLeft = 0; uLeft = 0;
    end else begin
      #1;
      sOutV = 1'b0;
      uOutV = 1'b0;
      if (sLeft > 0) begin
        sLeft--;
        if (sLeft == 0) begin sOutV = 1'b1; sOutD = sRes; sOutCnt++; end
      end else if (sDdQ.size() > 0 && sDvQ.size() > 0) begin
        sRes = divRef(1'b0, sDdQ.pop_front(), sDvQ.pop_front());
        sLeft = ipLat;
      end
      if (uLeft > 0) begin
        uLeft--;
        if (uLeft == 0) begin uOutV = 1'b1; uOutD = uRes; end
      end else if (uDdQ.size() > 0 && uDvQ.size() > 0) begin
        uRes = divRef(1'b1, uDdQ.pop_front(), uDvQ.pop_front());
        uLeft = ipLat;
      end
    end
  end

  // Transaction model: 0 none, 1 outstanding, 2 result owed to ES, 3 flushed.
  int mPhase = 0;
  logic mSel = 1'b0;
  logic [63:0] mExp = '0;
  logic pV[4], pR[4], pFlush;
  logic [W-1:0] pD[4];

  task automatic trackChannel(input string name, input int i, input logic v, input logic r, input logic [W-1:0] d);
    if (pV[i] && !pR[i] && !pFlush) begin
      checkOutput({name, "_held"}, 64'(v), 64'd1);
      checkOutput({name, "_stable"}, 64'(d), 64'(pD[i]));
    end
    pV[i] = v;
    pR[i] = r;
    pD[i] = d;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      mPhase = 0;
      for (int i = 0; i < 4; i++) pV[i] = 1'b0;
      pFlush = 1'b0;
    end else begin
      checkOutput("ready_go", 64'(readyGo), 64'(mPhase == 2));
      if (mPhase == 2) begin
        checkOutput("res_lo", 64'(resLo), 64'(mExp[63:32]));
        checkOutput("res_hi", 64'(resHi), 64'(mExp[31:0]));
      end
      if (mPhase != 0)
        checkOutput("other_ip_valid", 64'(mSel ? {sDdV, sDvV} : {uDdV, uDvV}), 64'd0);
      trackChannel("s_dividend", 0, sDdV, sDdR, sDdD);
      trackChannel("s_divisor", 1, sDvV, sDvR, sDvD);
      trackChannel("u_dividend", 2, uDdV, uDdR, uDdD);
      trackChannel("u_divisor", 3, uDvV, uDvR, uDvD);
      pFlush = flush;
      if (mPhase == 3 && !busy) mPhase = 0;
      if (mPhase == 0) begin
        if (reqValid && (reqOp == 2'b01 || reqOp == 2'b10) && !flush) begin
          mPhase = 1;
          mSel = reqOp[1];
          mExp = divRef(reqOp[1], src1, src2);
        end
      end else if (mPhase == 1) begin
        if (flush) mPhase = 3;
        else if (mSel ? uOutV : sOutV) mPhase = 2;
      end else if (mPhase == 2) begin
        if (flush || resAccept) mPhase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    reqValid = 1'b1;
    reqOp = op;
    src1 = a;
    src2 = b;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (readyGo !== 1'b1 && n < 40) begin tick(); n++; end
    checkOutput({name, "_ready_seen"}, 64'(readyGo), 64'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(); n++; end
    checkOutput({name, "_idle_seen"}, 64'(busy), 64'd0);
  endtask

  task automatic finishTxn(input string name);
    resAccept = 1'b1;
    tick();
    resAccept = 1'b0;
    reqValid = 1'b0;
    checkOutput({name, "_idle_after_accept"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int ddOn, dvOn, cnt0;
    resetn = 1'b1;
    reqValid = 1'b0; reqOp = 2'b00; src1 = '0; src2 = '0;
    flush = 1'b0; resAccept = 1'b0;
    sDdR = 1'b1; sDvR = 1'b1; uDdR = 1'b1; uDvR = 1'b1;
    sOutD = '0; uOutD = '0;
    #1 resetn = 1'b0;
    #2;
    checkOutput("rst_ready_go", 64'(readyGo), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_res", 64'({resHi, resLo}), 64'd0);
    checkOutput("rst_valids", 64'({sDdV, sDvV, uDdV, uDvV}), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Signed -7 / 2
    applyStimulus(2'b01, 32'hFFFF_FFF9, 32'd2);
    tick();
    checkOutput("sig_valids", 64'({sDdV, sDvV}), 64'd3);
    checkOutput("sig_busy", 64'(busy), 64'd1);
    waitReady("sig");
    checkOutput("sig_lo", 64'(resLo), 64'hFFFF_FFFD);
    checkOutput("sig_hi", 64'(resHi), 64'hFFFF_FFFF);
    finishTxn("sig");

    // Unsigned 0xFFFFFFF9 / 2
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    tick();
    checkOutput("uns_valids", 64'({uDdV, uDvV, sDdV, sDvV}), 64'hC);
    waitReady("uns");
    checkOutput("uns_lo", 64'(resLo), 64'h7FFF_FFFC);
    checkOutput("uns_hi", 64'(resHi), 64'd1);
    finishTxn("uns");

    // Divisor tready held off for three cycles
    sDvR = 1'b0;
    applyStimulus(2'b01, 32'hFFFF_FF9C, 32'd7);
    tick();
    ddOn = 0; dvOn = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) sDvR = 1'b1;
      ddOn += int'(sDdV);
      dvOn += int'(sDvV);
      tick();
    end
    checkOutput("stagger_dd_cycles", 64'(ddOn), 64'd1);
    checkOutput("stagger_dv_cycles", 64'(dvOn), 64'd4);
    waitReady("stagger");
    checkOutput("stagger_res", 64'({resLo, resHi}), 64'hFFFF_FFF2_FFFF_FFFE);
    finishTxn("stagger");

    // Flush after dividend accepted, divisor still pending
    sDvR = 1'b0;
    applyStimulus(2'b01, 32'h11, 32'd3);
    tick();
    tick();
    flush = 1'b1;
    reqValid = 1'b0;
    tick();
    flush = 1'b0;
    checkOutput("flush_dv_still_valid", 64'({sDdV, sDvV}), 64'd1);
    sDvR = 1'b1;
    tick();
    waitIdle("flush_drain");
    checkOutput("flush_ready_low", 64'(readyGo), 64'd0);
    checkOutput("flush_pair_sync", 64'(sDdCnt - sDvCnt), 64'd0);
    applyStimulus(2'b01, 32'd100, 32'd7);
    tick();
    waitReady("after_flush");
    checkOutput("after_flush_lo", 64'(resLo), 64'd14);
    checkOutput("after_flush_hi", 64'(resHi), 64'd2);
    finishTxn("after_flush");

    // Flush while DONE
    applyStimulus(2'b01, 32'd32, 32'd5);
    tick();
    waitReady("done_flush");
    flush = 1'b1;
    reqValid = 1'b0;
    tick();
    flush = 1'b0;
    checkOutput("done_flush_idle", 64'({busy, readyGo}), 64'd0);

    // Flush in SEND with nothing handed over
    sDdR = 1'b0; sDvR = 1'b0;
    cnt0 = sDdCnt + sDvCnt;
    applyStimulus(2'b01, 32'd9, 32'd4);
    tick();
    flush = 1'b1;
    reqValid = 1'b0;
    tick();
    flush = 1'b0;
    checkOutput("send_flush_idle", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("send_flush_no_valid", 64'({sDdV, sDvV}), 64'd0);
      tick();
    end
    checkOutput("send_flush_no_hs", 64'(sDdCnt + sDvCnt - cnt0), 64'd0);
    sDdR = 1'b1; sDvR = 1'b1;

    // req_op = 11 is not a request
    applyStimulus(2'b11, 32'd9, 32'd4);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("op11_idle", 64'(busy), 64'd0);
    end
    reqValid = 1'b0;
    tick();

    // Asynchronous reset while waiting for the IP
    ipLat = 10;
    applyStimulus(2'b10, 32'd9, 32'd2);
    tick(); tick(); tick();
    #2 resetn = 1'b0;
    #1;
    reqValid = 1'b0;
    checkOutput("async_rst_ready_go", 64'(readyGo), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_res", 64'({resHi, resLo}), 64'd0);
    checkOutput("async_rst_valids", 64'({sDdV, sDvV, uDdV, uDvV}), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    ipLat = 5;
    tick();
    applyStimulus(2'b10, 32'd9, 32'd2);
    tick();
    waitReady("post_rst");
    checkOutput("post_rst_res", 64'({resLo, resHi}), 64'h0000_0004_0000_0001);
    finishTxn("post_rst");

    tick(); tick();
    checkOutput("s_ip_pairs", 64'(sDdCnt - sDvCnt), 64'd0);
    checkOutput("s_ip_results", 64'(sDdCnt - sOutCnt), 64'd0);
    checkOutput("u_ip_pairs", 64'(uDdCnt - uDvCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Execute-stage scheduler for the shared multi-cycle divider resource: one signed divider IP (div) and one unsigned divider IP (divu), both with AXI-stream style channels.
- Accepts a single divide request from the execute stage and latches its operands.
- Drives the dividend/divisor channels of the selected IP, waits for its result and holds {hi=remainder, lo=quotient} until the execute stage consumes it.
- Guarantees the IPs never get out of step when an in-flight divide is flushed by an exception.

Parameters:
DATA_WD, 32, operand width; the IP result bus is 2*DATA_WD.

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  ES holds a valid div/divu; held high until ready_go && res_accept
req_op  input  2  bit0=div (signed), bit1=divu; 00 or 11 = no request
req_src1  input  DATA_WD  dividend (rs value)
req_src2  input  DATA_WD  divisor (rt value)
flush  input  1  cancel the current request (exception/eret); single-cycle pulse
res_accept  input  1  ES advances this cycle (es_allowin of next stage)
ready_go  output  1  result valid; ES may leave
res_hi  output  DATA_WD  remainder
res_lo  output  DATA_WD  quotient
busy  output  1  state != IDLE
s_dividend_tvalid, s_divisor_tvalid  output  1 each  signed IP input valids
s_dividend_tready, s_divisor_tready  input  1 each  signed IP input readies
s_dout_tvalid  input  1  signed IP result valid (IP has no dout tready)
s_dout_tdata  input  2*DATA_WD  {quotient, remainder}
u_dividend_tvalid, u_divisor_tvalid  output  1 each  unsigned IP input valids
u_dividend_tready, u_divisor_tready  input  1 each  unsigned IP input readies
u_dout_tvalid  input  1  unsigned IP result valid
u_dout_tdata  input  2*DATA_WD  {quotient, remainder}

Behaviour:
- States: IDLE, SEND, WAIT, DONE, DRAIN.
- Reset values (async, resetn=0): state=IDLE, all tvalids 0, ready_go 0, busy 0, res_hi/res_lo 0, sent flags 0, cancel 0, sel 0.
- IDLE: on req_valid && req_op one-hot && !flush:
  - latch src1, src2 and sel (1=unsigned); clear dd_sent/dv_sent; go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - x_dividend_tvalid = (sel matches) && !dd_sent; x_divisor_tvalid = (sel matches) && !dv_sent. The other IP's valids are 0.
  - tdata is the latched operands, stable while tvalid is high.
  - Each channel sets its sent flag on tvalid && tready; the two channels are independent and may complete in the same or different cycles.
  - When both are sent (counting the current cycle's handshakes): go to WAIT, or to DRAIN if cancel is set.
  - First tvalid appears the cycle after the request is sampled, so minimum latency is request to SEND(1), then WAIT, then DONE.
- WAIT: on the selected IP's dout_tvalid, latch res_lo=tdata[2W-1:W] and res_hi=tdata[W-1:0], then go to DONE. The unselected IP's dout_tvalid is ignored.
- DONE: ready_go=1 and the result is held stable. On res_accept go to IDLE; a new request is sampled no earlier than the next cycle.
- flush handling by state:
  - IDLE: the request is ignored.
  - SEND with neither channel sent: go to IDLE immediately, tvalids drop.
  - SEND with one channel sent: set cancel and keep sending the other channel (the IP must receive a full pair), then go to DRAIN.
  - WAIT: go to DRAIN.
  - DONE: go to IDLE, result discarded.
- DRAIN: wait for the selected dout_tvalid, discard it, go to IDLE. ready_go=0 throughout.
- A flush arriving in the same cycle as a channel handshake counts that handshake as sent.
- ready_go is 1 only in DONE and is never high with cancel set.
- Divide by zero is not special-cased; the IP output is passed through unchanged.
- Reset mid-operation returns to IDLE immediately; the IPs are assumed reset by the same resetn.
- ES must keep req_valid and operands stable until ready_go && res_accept. Operands are latched, so changes after IDLE are ignored.

Test Plan:
- Signed: req_op=01, src1=0xFFFFFFF9 (-7), src2=2, both treadies high, dout_tvalid 5 cycles later -> ready_go rises the cycle after dout_tvalid with res_lo=0xFFFFFFFD and res_hi=0xFFFFFFFF; state returns to IDLE the cycle after res_accept.
- Unsigned: req_op=10, 0xFFFFFFF9/2 -> res_lo=0x7FFFFFFC, res_hi=1; s_* tvalids stay 0 for the whole operation.
- Staggered readies: dividend_tready high in cycle 1, divisor_tready delayed 3 cycles -> dividend_tvalid drops after 1 cycle, divisor_tvalid stays high for 4 cycles; WAIT is entered only after the second handshake.
- Flush after the dividend is accepted but before the divisor -> divisor is still sent, state goes to DRAIN, the later dout is discarded, ready_go stays 0, IDLE is reached; a following div 100/7 returns lo=14, hi=2, proving the IP stayed in sync.
- Flush in DONE, and flush in SEND with nothing sent -> IDLE the next cycle, no extra tvalid pulses; req_op=11 -> no state change.
- resetn asserted low during WAIT -> all outputs 0 and IDLE with no clock edge; after deassertion a new request completes normally.
